dma_bar_arb_mo: RTL and testbench
=================================

Name: dma_bar_arb_mo

Overview:
- Memory-barrier arbiter for the DMA engine, DMA_THREAD_CNT threads.
- Each thread may raise a barrier request. Up to MAX_OUTSTANDING barriers may be in flight at once, with at most one per thread.
- Arbitration is selectable: fixed priority or round-robin.
- Sits between the DMA thread controllers and the memory-ordering path. It tracks which threads hold an outstanding barrier and retires each one on that thread's done pulse.

Parameters:
- DMA_THREAD_CNT, 4, number of DMA threads (>=2).
- MAX_OUTSTANDING, 2, maximum barriers in flight (1..DMA_THREAD_CNT).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock
- rstn  input  1  reset; synchronous, active-low
- req  input  DMA_THREAD_CNT  per-thread barrier request; level, held until granted
- gnt  output  DMA_THREAD_CNT  one-hot or zero grant; combinational, single-cycle
- done  input  DMA_THREAD_CNT  per-thread barrier-complete pulse
- pending  output  DMA_THREAD_CNT  registered, per-thread outstanding-barrier flag
- outstanding_cnt  output  $clog2(MAX_OUTSTANDING+1)  registered count of barriers in flight
- is_outstanding_barrier  output  1  (outstanding_cnt != 0)
- full  output  1  (outstanding_cnt == MAX_OUTSTANDING)
- timeout_err  output  1  sticky watchdog error

Behaviour:
- Reset values: pending = 0, outstanding_cnt = 0, round-robin pointer = 0, watchdog = 0, timeout_err = 0.
- Derived at reset: gnt = 0, is_outstanding_barrier = 0, full = 0.
- Eligibility: elig = req & ~pending.
  - gnt = 0 whenever full = 1 or elig = 0.
  - Evaluated only against registered state. Same-cycle done does not free a slot for gnt.
- ARB_MODE 0: gnt = lowest set bit of elig.
- ARB_MODE 1: search elig starting at index ptr, wrapping modulo DMA_THREAD_CNT. On any grant to index k, ptr <= (k+1) mod DMA_THREAD_CNT. With no grant, ptr holds.
- Grant accounting: on gnt[k], pending[k] <= 1 next cycle. Zero-latency grant: req[k] seen in cycle t gives gnt[k] in cycle t if eligible. The requester must drop req[k] the cycle after the grant; while pending[k] = 1, req[k] is ignored.
- Done accounting: on done[j] with pending[j] = 1, pending[j] <= 0.
  - done[j] with pending[j] = 0 is ignored (assertion fires in simulation).
  - Multiple done bits in one cycle are all retired.
- Count update: outstanding_cnt_next = outstanding_cnt + |gnt - popcount(done & pending). Result is never negative and never exceeds MAX_OUTSTANDING.
- Simultaneous gnt[k] and done[j]: both apply, so the count is unchanged.
  - done[k] in the grant cycle of k is ignored, because pending[k] = 0 in that cycle.
- MAX_OUTSTANDING = 1 with ARB_MODE 0 reproduces the legacy single-barrier behaviour.
- Invariant: outstanding_cnt == popcount(pending) at all times (asserted).
- Reset mid-operation: all pending barriers are dropped and the count is cleared. Late done pulses after reset are ignored.
- Assertions (non-synthesis):
  - gnt not X.
  - gnt one-hot or zero.
  - gnt == 0 when full.
  - gnt & pending == 0.
  - count/pending invariant holds.

Optional Feature:
- Macro: DMA_BAR_ARB_TIMEOUT_EN.
- Enabled:
  - A watchdog counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle that is_outstanding_barrier = 1 and no retiring done occurs.
  - It clears to 0 on any retiring done or when outstanding_cnt = 0.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err <= 1. It is sticky until reset.
- Disabled: no counter is built; timeout_err is tied to 0.

Test Plan:
- ARB_MODE 1, MAX 2, req = 4'b1111 held:
  - cycle 0: gnt = 0001; cycle 1: gnt = 0010; cycle 2: gnt = 0; full = 1, cnt = 2.
  - done = 0001 → next cycle gnt = 0100.
- ARB_MODE 0, req = 4'b1010 → gnt = 0010. After done[1] with req = 1010, gnt = 0010 again (no rotation).
- Full plus simultaneous done:
  - cnt = 2 (pending = 0011), done = 0001 and req = 0100 in the same cycle → gnt = 0 that cycle.
  - Next cycle gnt = 0100; cnt goes 2 → 1 → 2.
- Spurious done: done = 1000 with pending = 0000 → cnt stays 0, pending stays 0, assertion reported.
- Mid-operation reset: pending = 0011, rstn = 0 for one cycle → pending = 0, cnt = 0, is_outstanding_barrier = 0. A done = 0001 after reset has no effect.
- DMA_BAR_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8:
  - One grant, no done → timeout_err = 1 at cycle 8 after the grant; it stays 1 after a later done.
  - Without the macro, timeout_err stays 0.

Source files
------------

// File: rtl/dma_bar_arb_mo_if.sv
// rtl/dma_bar_arb_mo_if.sv - thread-side / arbiter-side signal bundle for dma_bar_arb_mo
interface dma_bar_arb_mo_if #(
    parameter int DMA_THREAD_CNT  = 4,
    parameter int MAX_OUTSTANDING = 2
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [DMA_THREAD_CNT-1:0] req;
    logic [DMA_THREAD_CNT-1:0] gnt;
    logic [DMA_THREAD_CNT-1:0] done;
    logic [DMA_THREAD_CNT-1:0] pending;
    logic [CW-1:0]             outstanding_cnt;
    logic                      is_outstanding_barrier;
    logic                      full;
    logic                      timeout_err;

    // master: DMA thread controllers; slave: the barrier arbiter
    modport master (
        output req, done,
        input  gnt, pending, outstanding_cnt, is_outstanding_barrier, full, timeout_err
    );

    modport slave (
        input  req, done,
        output gnt, pending, outstanding_cnt, is_outstanding_barrier, full, timeout_err
    );
endinterface

// File: rtl/dma_bar_arb_mo.sv
// rtl/dma_bar_arb_mo.sv - multi-outstanding memory-barrier arbiter (optional watchdog: DMA_BAR_ARB_TIMEOUT_EN)
module dma_bar_arb_mo #(
    parameter int DMA_THREAD_CNT  = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 1,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    dma_bar_arb_mo_if.slave   bus
);
    localparam int N  = DMA_THREAD_CNT;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [N-1:0]  pending_q;
    logic [N-1:0]  elig;
    logic [N-1:0]  gnt;
    logic [N-1:0]  retire;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] retire_cnt;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_next;
    logic          full;

    // Only registered state gates eligibility; a same-cycle done never frees a slot.
    assign elig   = bus.req & ~pending_q;
    assign retire = bus.done & pending_q;
    assign full   = (cnt_q == MAX_CNT);

    always_comb begin : arb
        int   start;
        int   idx;
        logic found;
        gnt      = '0;
        ptr_next = ptr_q;
        found    = 1'b0;
        idx      = 0;
        start    = (ARB_MODE == 1) ? int'(ptr_q) : 0;
        for (int i = 0; i < N; i++) begin
            idx = start + i;
            if (idx >= N) idx = idx - N;
            if (!found && !full && elig[PW'(idx)]) begin
                found            = 1'b1;
                gnt[PW'(idx)]    = 1'b1;
                ptr_next         = PW'((idx + 1) % N);
            end
        end
    end

    always_comb begin
        retire_cnt = '0;
        for (int j = 0; j < N; j++) begin
            if (retire[j]) retire_cnt = retire_cnt + CW'(1);
        end
    end

    assign cnt_next = cnt_q + ((|gnt) ? CW'(1) : '0) - retire_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending_q <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
        end else begin
            pending_q <= (pending_q & ~retire) | gnt;
            cnt_q     <= cnt_next;
            ptr_q     <= ptr_next;
        end
    end

`ifdef DMA_BAR_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wd_q;
    logic          err_q;

    // Counter saturates at the limit so the sticky error cannot be missed by wrap-around.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (cnt_q == '0 || (|retire)) begin
                wd_q <= '0;
            end else if (wd_q != WD_MAX) begin
                wd_q <= wd_q + WW'(1);
            end
            if (wd_q == WD_MAX) err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign bus.timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign bus.gnt                    = gnt;
    assign bus.pending                = pending_q;
    assign bus.outstanding_cnt        = cnt_q;
    assign bus.is_outstanding_barrier = (cnt_q != '0);
    assign bus.full                   = full;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!$isunknown(gnt)) else $error("gnt carries X");
            assert ($onehot0(gnt)) else $error("gnt not one-hot");
            assert (!(full && (|gnt))) else $error("gnt while full");
            assert ((gnt & pending_q) == '0) else $error("gnt to a pending thread");
            assert ($countones(pending_q) == int'(cnt_q)) else $error("count does not match pending");
            if ((bus.done & ~pending_q) != '0) $warning("done on a thread with no barrier ignored");
        end
    end
`endif
endmodule

// File: tb/tb_dma_bar_arb_mo.sv
// tb/tb_dma_bar_arb_mo.sv - randomized and directed bench for dma_bar_arb_mo against a queue-free reference model
module tb_dma_bar_arb_mo;
    localparam int N   = 4;
    localparam int MAX = 2;
    localparam int TO  = 8;
    localparam int CW  = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dma_bar_arb_mo_if #(.DMA_THREAD_CNT(N), .MAX_OUTSTANDING(MAX)) bus_rr ();
    dma_bar_arb_mo_if #(.DMA_THREAD_CNT(N), .MAX_OUTSTANDING(MAX)) bus_fp ();

    dma_bar_arb_mo #(.DMA_THREAD_CNT(N), .MAX_OUTSTANDING(MAX), .ARB_MODE(1), .TIMEOUT_CYCLES(TO))
        u_rr (.clk(clk), .rstn(rstn), .bus(bus_rr));
    dma_bar_arb_mo #(.DMA_THREAD_CNT(N), .MAX_OUTSTANDING(MAX), .ARB_MODE(0), .TIMEOUT_CYCLES(TO))
        u_fp (.clk(clk), .rstn(rstn), .bus(bus_fp));

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] m_pend [2];
    int           m_ptr  [2];
    logic [N-1:0] g_rr, g_fp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Grant rule: nothing when full, else first requesting idle thread from the search start.
    function automatic logic [N-1:0] model_gnt(input int mode, input logic [N-1:0] req,
                                               input logic [N-1:0] pend, input int ptr);
        int k;
        if ($countones(pend) >= MAX) return '0;
        for (int i = 0; i < N; i++) begin
            k = ((mode == 1 ? ptr : 0) + i) % N;
            if (req[k] && !pend[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    task automatic check_dut(input string name, input int d, input int mode,
                             input logic [N-1:0] pend_o, input logic [CW-1:0] cnt_o,
                             input logic io_o, input logic full_o, input logic to_o,
                             input logic [N-1:0] gnt_o, input logic rst_n,
                             input logic [N-1:0] req, input logic [N-1:0] done);
        logic [N-1:0] exp;
        int c;
        c = $countones(m_pend[d]);
        check({name, "_pending"}, pend_o, m_pend[d]);
        check({name, "_cnt"}, cnt_o, c);
        check({name, "_is_out"}, io_o, c != 0);
        check({name, "_full"}, full_o, c == MAX);
`ifndef DMA_BAR_ARB_TIMEOUT_EN
        check({name, "_timeout"}, to_o, 1'b0);
`endif
        exp = model_gnt(mode, req, m_pend[d], m_ptr[d]);
        check({name, "_gnt"}, gnt_o, exp);
        if (!rst_n) begin
            m_pend[d] = '0;
            m_ptr[d]  = 0;
        end else begin
            m_pend[d] = (m_pend[d] & ~done) | exp;
            for (int k = 0; k < N; k++) if (exp[k]) m_ptr[d] = (k + 1) % N;
        end
    endtask

    task automatic cycle(input logic rst_n, input logic [N-1:0] req,
                         input logic [N-1:0] done_rr, input logic [N-1:0] done_fp);
        @(posedge clk);
        #1;
        rstn        = rst_n;
        bus_rr.req  = req;
        bus_rr.done = done_rr;
        bus_fp.req  = req;
        bus_fp.done = done_fp;
        @(negedge clk);
        g_rr = bus_rr.gnt;
        g_fp = bus_fp.gnt;
        check_dut("rr", 0, 1, bus_rr.pending, bus_rr.outstanding_cnt, bus_rr.is_outstanding_barrier,
                  bus_rr.full, bus_rr.timeout_err, bus_rr.gnt, rst_n, req, done_rr);
        check_dut("fp", 1, 0, bus_fp.pending, bus_fp.outstanding_cnt, bus_fp.is_outstanding_barrier,
                  bus_fp.full, bus_fp.timeout_err, bus_fp.gnt, rst_n, req, done_fp);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [N-1:0] r;
        bus_rr.req = '0; bus_rr.done = '0;
        bus_fp.req = '0; bus_fp.done = '0;
        m_pend[0] = '0; m_pend[1] = '0;
        m_ptr[0]  = 0;  m_ptr[1]  = 0;

        do_reset();
        cycle(1'b1, 4'b1111, '0, '0);
        check("rr_rot0", g_rr, 4'b0001);
        check("fp_rot0", g_fp, 4'b0001);
        cycle(1'b1, 4'b1111, '0, '0);
        check("rr_rot1", g_rr, 4'b0010);
        cycle(1'b1, 4'b1111, '0, '0);
        check("rr_rot2_full", g_rr, 4'b0000);
        check("rr_full_flag", bus_rr.full, 1'b1);
        check("rr_cnt2", bus_rr.outstanding_cnt, 2);
        cycle(1'b1, 4'b1111, 4'b0001, 4'b0001);
        check("rr_done_same_cycle", g_rr, 4'b0000);
        cycle(1'b1, 4'b1111, '0, '0);
        check("rr_after_done", g_rr, 4'b0100);
        check("fp_after_done", g_fp, 4'b0001);

        do_reset();
        cycle(1'b1, 4'b1010, '0, '0);
        check("fp_low_bit", g_fp, 4'b0010);
        cycle(1'b1, 4'b0000, 4'b0010, 4'b0010);
        cycle(1'b1, 4'b1010, '0, '0);
        check("fp_no_rotation", g_fp, 4'b0010);
        check("rr_rotated", g_rr, 4'b1000);

        do_reset();
        cycle(1'b1, 4'b0011, '0, '0);
        cycle(1'b1, 4'b0011, '0, '0);
        cycle(1'b1, 4'b0100, 4'b0001, 4'b0001);
        check("full_done_gnt", g_rr, 4'b0000);
        check("full_done_cnt", bus_rr.outstanding_cnt, 2);
        cycle(1'b1, 4'b0100, '0, '0);
        check("slot_freed_gnt", g_rr, 4'b0100);
        check("slot_freed_cnt", bus_rr.outstanding_cnt, 1);
        cycle(1'b1, '0, '0, '0);
        check("refilled_cnt", bus_rr.outstanding_cnt, 2);

        do_reset();
        cycle(1'b1, '0, 4'b1000, 4'b1000);
        cycle(1'b1, '0, '0, '0);
        check("spurious_cnt", bus_rr.outstanding_cnt, 0);
        check("spurious_pending", bus_rr.pending, 4'b0000);

        do_reset();
        cycle(1'b1, 4'b0011, '0, '0);
        cycle(1'b1, 4'b0011, '0, '0);
        cycle(1'b1, '0, '0, '0);
        check("pre_reset_pending", bus_rr.pending, 4'b0011);
        cycle(1'b0, '0, '0, '0);
        cycle(1'b1, '0, 4'b0001, 4'b0001);
        check("post_reset_pending", bus_rr.pending, 4'b0000);
        check("post_reset_is_out", bus_rr.is_outstanding_barrier, 1'b0);
        cycle(1'b1, '0, '0, '0);
        check("late_done_cnt", bus_rr.outstanding_cnt, 0);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = N'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                cycle(1'b0, r, '0, '0);
            end else begin
                cycle(1'b1, r, N'($urandom & $urandom) & m_pend[0],
                               N'($urandom & $urandom) & m_pend[1]);
            end
        end

        do_reset();
        cycle(1'b1, 4'b0001, '0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, '0, '0, '0);
        check("watchdog_early", bus_rr.timeout_err, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, '0, '0, '0);
`ifdef DMA_BAR_ARB_TIMEOUT_EN
        check("watchdog_fired", bus_rr.timeout_err, 1'b1);
`else
        check("watchdog_absent", bus_rr.timeout_err, 1'b0);
`endif
        cycle(1'b1, '0, 4'b0001, 4'b0001);
        cycle(1'b1, '0, '0, '0);
`ifdef DMA_BAR_ARB_TIMEOUT_EN
        check("watchdog_sticky", bus_rr.timeout_err, 1'b1);
`else
        check("watchdog_still_low", bus_rr.timeout_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
